bnn_fc_layer: RTL and testbench
===============================

# bnn_fc_layer

Parametrised binary fully-connected layer engine for the BNN datapath. Streams PAR-bit weight and activation words from single-port synchronous memories and computes an XNOR-popcount per output neuron. Each neuron's count is compared against a runtime threshold, and the resulting 1-bit activation is written to the next layer's activation memory. One instance runs one layer per start pulse; the top-level sequencer chains layers by re-pointing memories and re-starting.

## Interface
- N_IN, 784, input neurons per row (≥1)
- N_OUT, 1024, output neurons (≥1)
- PAR, 32, bits processed per cycle (memory word width)
- ACC_W, 12, accumulator width; must satisfy 2^ACC_W > N_IN
- W_ADDR_LEN, 20, weight address width; must hold N_OUT*WPR-1, where WPR = ceil(N_IN/PAR)
- X_ADDR_LEN, 10, input activation address width; must hold WPR-1
- Y_ADDR_LEN, 10, output activation address width; must hold N_OUT-1
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin layer; honoured only in IDLE
- en  in  1  issue enable; low stalls new reads
- thresh  in  ACC_W  activation threshold, sampled at accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle completion pulse
- w_addr  out  W_ADDR_LEN  weight word address = o*WPR + k
- w_rd  out  1  weight read strobe
- w_data  in  PAR  weight word, valid the cycle after w_rd
- x_addr  out  X_ADDR_LEN  input word address = k
- x_rd  out  1  input read strobe (always equal to w_rd)
- x_data  in  PAR  input word, valid the cycle after x_rd
- y_addr  out  Y_ADDR_LEN  output neuron index o
- y_we  out  1  output write strobe
- y_data  out  1  activation bit

## Operation
- States:
  - IDLE: start → RUN. On entry to RUN: capture thresh, clear counters and accumulator, set busy.
  - RUN: each cycle with en=1, issue one read at (o,k) with w_rd=x_rd=1. Then advance k; on k=WPR-1, set k=0 and o++. After issuing (N_OUT-1, WPR-1), go to DRAIN.
  - DRAIN: wait until no read is in flight and the last write has been issued, then go to DONE.
  - DONE: done=1 for one cycle, busy=0, return to IDLE.
- Read pipeline:
  - A valid bit plus k/o tags are registered alongside each issued read.
  - Returned data is consumed exactly once regardless of en, so a stall never loses in-flight data.
- Bit mapping: bit i of word k is input neuron k*PAR+i.
- Match vector: m = ~(w_data ^ x_data). On the last word (k=WPR-1), bits i ≥ N_IN-(WPR-1)*PAR are forced to 0. No masking applies when PAR divides N_IN.
- Popcount pc = popcount(m), width clog2(PAR+1), zero-extended to ACC_W.
- Accumulation, in the data-return cycle:
  - Not the last word: acc ← acc + pc.
  - Last word: y_data ← (acc+pc ≥ thresh) unsigned, y_addr ← o_tag, y_we ← 1, and acc ← 0.
  - The next row's first word accumulates into the cleared acc the following cycle; there is no bubble between rows.
- Overflow cannot occur under the ACC_W constraint; no saturation logic.
- start while busy: ignored. thresh changes while busy: ignored.
- Reset (rst=0), at any time: state=IDLE, acc=0, counters=0, valid=0. All outputs go to 0: busy, done, w_rd, x_rd, y_we, y_data, w_addr, x_addr, y_addr. No partial write completes after reset.

## Timing
- Start is accepted at edge E0. The first read is issued in the cycle after E0.
- With no stalls, reads occupy T = N_OUT*WPR consecutive cycles (cycles 1..T).
- Row o's y_we is high in cycle (o+1)*WPR+2. Consecutive y_we pulses are spaced WPR cycles apart; for WPR=1 that is back-to-back.
- The last y_we is in cycle T+2. done is high in cycle T+3; busy is high in cycles 1..T+2.
- Each cycle en=0 in RUN delays all later events by exactly one cycle.
- Memory read latency is fixed at 1 cycle; no other latency is supported.

## Test plan
- All-ones: N_IN=8, PAR=4, N_OUT=2, w=x=all ones, thresh=5 → pc=4 per word, acc=8; y_we at cycles 4 and 6 with y_addr=0,1 and y_data=1; done at cycle 7.
- Masking: N_IN=6, PAR=4, N_OUT=1, w=x=0 (padding bits also 0).
  - thresh=6 → y_data=1.
  - thresh=7 → y_data=0. The count is 6, not 8.
- Threshold edge: N_IN=8, PAR=4, words giving acc=5.
  - thresh=5 → y_data=1.
  - thresh=6 → y_data=0.
- Stall: the all-ones case with en=0 for 3 cycles starting at cycle 2 → identical y values; y_we at cycles 7 and 9; done at cycle 10; no duplicate or missed accumulation.
- Reset mid-run: drive rst=0 at cycle 3 of the all-ones case → all outputs 0 immediately and no y_we. A new start after release yields the full correct sequence.
- Start while busy: pulse start again at cycle 2 → ignored; exactly N_OUT y_we pulses and one done pulse.

Source files
------------

// File: rtl/bnn_fc_layer.sv
// Binary fully-connected layer: streams weight/activation words, XNOR-popcounts
// each output row and writes one thresholded activation bit per neuron.
module bnn_fc_layer #(
  parameter int N_IN       = 784,
  parameter int N_OUT      = 1024,
  parameter int PAR        = 32,
  parameter int ACC_W      = 12,
  parameter int W_ADDR_LEN = 20,
  parameter int X_ADDR_LEN = 10,
  parameter int Y_ADDR_LEN = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  en,
  input  logic [ACC_W-1:0]      thresh,
  output logic                  busy,
  output logic                  done,
  output logic [W_ADDR_LEN-1:0] w_addr,
  output logic                  w_rd,
  input  logic [PAR-1:0]        w_data,
  output logic [X_ADDR_LEN-1:0] x_addr,
  output logic                  x_rd,
  input  logic [PAR-1:0]        x_data,
  output logic [Y_ADDR_LEN-1:0] y_addr,
  output logic                  y_we,
  output logic                  y_data
);

  localparam int WPR  = (N_IN + PAR - 1) / PAR;
  localparam int REM  = N_IN - (WPR - 1) * PAR;
  localparam int PC_W = $clog2(PAR + 1);
  // Only the low REM bits of the final word are real input neurons.
  localparam logic [PAR-1:0]        LAST_MASK = {PAR{1'b1}} >> (PAR - REM);
  localparam logic [X_ADDR_LEN-1:0] K_LAST    = X_ADDR_LEN'(WPR - 1);
  localparam logic [Y_ADDR_LEN-1:0] O_LAST    = Y_ADDR_LEN'(N_OUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                  state, state_nxt;
  logic [X_ADDR_LEN-1:0]   k;
  logic [Y_ADDR_LEN-1:0]   o;
  logic [ACC_W-1:0]        thr;
  logic [ACC_W-1:0]        acc;
  logic                    vld;
  logic                    last_tag;
  logic [Y_ADDR_LEN-1:0]   o_tag;
  logic                    issue;
  logic                    last_issue;
  logic [PAR-1:0]          match;
  logic [PC_W-1:0]         pc;
  logic [ACC_W-1:0]        sum;

  function automatic logic [PC_W-1:0] popcount(input logic [PAR-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < PAR; i++) c = c + PC_W'(v[i]);
    return c;
  endfunction

  assign issue      = (state == S_RUN) && en;
  assign last_issue = issue && (k == K_LAST) && (o == O_LAST);
  assign x_addr     = k;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    w_rd      = 1'b0;
    x_rd      = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        w_rd = issue;
        x_rd = issue;
        if (last_issue) state_nxt = S_DRAIN;
      end
      // The last row's write is registered in the same edge vld drops.
      S_DRAIN: begin
        busy = 1'b1;
        if (!vld) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k      <= '0;
      o      <= '0;
      w_addr <= '0;
      thr    <= '0;
    end else if (state == S_IDLE && start) begin
      k      <= '0;
      o      <= '0;
      w_addr <= '0;
      thr    <= thresh;
    end else if (issue) begin
      w_addr <= w_addr + 1'b1;
      if (k == K_LAST) begin
        k <= '0;
        o <= o + 1'b1;
      end else begin
        k <= k + 1'b1;
      end
    end
  end

  assign match = ~(w_data ^ x_data) & (last_tag ? LAST_MASK : {PAR{1'b1}});
  assign pc    = popcount(match);
  assign sum   = acc + ACC_W'(pc);

  // Returned data is consumed on vld alone, so en never drops an in-flight word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld      <= 1'b0;
      last_tag <= 1'b0;
      o_tag    <= '0;
      acc      <= '0;
      y_we     <= 1'b0;
      y_data   <= 1'b0;
      y_addr   <= '0;
    end else begin
      vld  <= issue;
      y_we <= 1'b0;
      if (issue) begin
        last_tag <= (k == K_LAST);
        o_tag    <= o;
      end
      if (vld) begin
        if (last_tag) begin
          y_we   <= 1'b1;
          y_data <= (sum >= thr);
          y_addr <= o_tag;
          acc    <= '0;
        end else begin
          acc <= sum;
        end
      end else if (state == S_IDLE && start) begin
        acc <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bnn_fc_layer.sv
// Self-checking bench for bnn_fc_layer: directed plan cases plus randomized
// memories/thresholds/stalls against a per-neuron XNOR-count reference.
module tb_bnn_fc_layer;
  localparam int N_IN = 6, PAR = 4, N_OUT = 2, ACC_W = 4;
  localparam int WAL = 4, XAL = 2, YAL = 2;
  localparam int WPR = (N_IN + PAR - 1) / PAR;
  localparam int T = N_OUT * WPR;
  localparam int RUN_MAX = 24;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, en = 1'b0;
  logic [ACC_W-1:0] thresh = '0;
  logic busy, done, w_rd, x_rd, y_we, y_data;
  logic [WAL-1:0] w_addr;
  logic [XAL-1:0] x_addr;
  logic [YAL-1:0] y_addr;
  logic [PAR-1:0] w_data = '0, x_data = '0;

  logic [PAR-1:0] wmem [T];
  logic [PAR-1:0] xmem [WPR];

  int n_tests = 0, n_fail = 0;
  int we_cyc[$], we_addr[$], done_cyc[$];
  bit we_dat[$];
  int busy_n, rd_n;

  bnn_fc_layer #(.N_IN(N_IN), .N_OUT(N_OUT), .PAR(PAR), .ACC_W(ACC_W),
                 .W_ADDR_LEN(WAL), .X_ADDR_LEN(XAL), .Y_ADDR_LEN(YAL)) dut (
    .clk(clk), .rst(rst), .start(start), .en(en), .thresh(thresh),
    .busy(busy), .done(done), .w_addr(w_addr), .w_rd(w_rd), .w_data(w_data),
    .x_addr(x_addr), .x_rd(x_rd), .x_data(x_data),
    .y_addr(y_addr), .y_we(y_we), .y_data(y_data));

  always #5 clk = ~clk;

  // Single-port synchronous memories, one cycle read latency.
  always @(posedge clk) begin
    if (w_rd && int'(w_addr) < T)   w_data <= wmem[w_addr];
    if (x_rd && int'(x_addr) < WPR) x_data <= xmem[x_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Matching input neurons of row o, straight from the bit-mapping rule.
  function automatic int ref_count(input int o);
    int cnt = 0;
    for (int i = 0; i < N_IN; i++)
      if (wmem[o*WPR + i/PAR][i%PAR] == xmem[i/PAR][i%PAR]) cnt++;
    return cnt;
  endfunction

  function automatic logic [31:0] outs();
    return 32'({busy, done, w_rd, x_rd, y_we, y_data, w_addr, x_addr, y_addr});
  endfunction

  task automatic run(input int th, input int sf, input int sl, input int restart_at, input int rst_at);
    we_cyc.delete(); we_addr.delete(); we_dat.delete(); done_cyc.delete();
    busy_n = 0; rd_n = 0;
    @(negedge clk); start = 1'b1; en = 1'b1; thresh = ACC_W'(th);
    @(posedge clk); #1;
    start = 1'b0; thresh = ACC_W'($urandom);
    for (int t = 1; t <= RUN_MAX; t++) begin
      en = !(t >= sf && t < sf + sl);
      start = (t == restart_at);
      if (t == rst_at) rst = 1'b0;
      if (rst_at > 0 && t == rst_at + 2) rst = 1'b1;
      @(negedge clk);
      if (t == rst_at) chk("rst_mid_outputs", outs(), 0);
      if (busy) busy_n++;
      if (w_rd) begin
        chk("w_addr", 32'(w_addr), rd_n);
        chk("x_addr", 32'(x_addr), rd_n % WPR);
        chk("x_rd", 32'(x_rd), 1);
        rd_n++;
      end
      if (y_we) begin
        we_cyc.push_back(t); we_addr.push_back(int'(y_addr)); we_dat.push_back(y_data);
      end
      if (done) done_cyc.push_back(t);
      @(posedge clk); #1;
    end
    start = 1'b0; en = 1'b0;
  endtask

  task automatic verify(input int th, input int sf, input int sl);
    int rdc[$];
    int c = 1;
    while (rdc.size() < T) begin
      if (!(c >= sf && c < sf + sl)) rdc.push_back(c);
      c++;
    end
    chk("n_we", we_cyc.size(), N_OUT);
    chk("n_done", done_cyc.size(), 1);
    chk("n_reads", rd_n, T);
    chk("busy_cycles", busy_n, rdc[T-1] + 2);
    if (done_cyc.size() > 0) chk("done_cycle", done_cyc[0], rdc[T-1] + 3);
    for (int o = 0; o < N_OUT; o++) begin
      if (o < we_cyc.size()) begin
        chk("we_cycle", we_cyc[o], rdc[(o+1)*WPR - 1] + 2);
        chk("y_addr", we_addr[o], o);
        chk("y_data", 32'(we_dat[o]), 32'(ref_count(o) >= th));
      end
    end
  endtask

  task automatic fill(input logic [PAR-1:0] wv, input logic [PAR-1:0] xv);
    for (int i = 0; i < T; i++) wmem[i] = wv;
    for (int i = 0; i < WPR; i++) xmem[i] = xv;
  endtask

  initial begin
    fill('0, '0);
    #1 chk("reset_outputs", outs(), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // All-ones: 6 matches per row, above threshold 5.
    fill('1, '1);
    run(5, 0, 0, 0, 0); verify(5, 0, 0);

    // Zeros match everywhere, padding must not count: 6, not 8.
    fill('0, '0);
    run(6, 0, 0, 0, 0); verify(6, 0, 0);
    run(7, 0, 0, 0, 0); verify(7, 0, 0);

    // Count exactly 5: 3 matches in word 0, 2 real bits in word 1.
    fill('0, '0);
    xmem[0] = 4'b0001;
    run(5, 0, 0, 0, 0); verify(5, 0, 0);
    run(6, 0, 0, 0, 0); verify(6, 0, 0);

    // Stall for cycles 2..4.
    fill('1, '1);
    run(5, 2, 3, 0, 0); verify(5, 2, 3);

    // Second start while busy is ignored.
    run(5, 0, 0, 2, 0); verify(5, 0, 0);

    // Reset mid-run, then a clean run.
    run(5, 0, 0, 0, 3);
    chk("rst_no_we", we_cyc.size(), 0);
    chk("rst_no_done", done_cyc.size(), 0);
    run(5, 0, 0, 0, 0); verify(5, 0, 0);

    for (int it = 0; it < 25; it++) begin
      int th, sf, sl;
      for (int i = 0; i < T; i++) wmem[i] = PAR'($urandom);
      for (int i = 0; i < WPR; i++) xmem[i] = PAR'($urandom);
      th = $urandom_range(0, 8);
      sf = $urandom_range(1, 5);
      sl = $urandom_range(0, 3);
      run(th, sf, sl, 0, 0); verify(th, sf, sl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
